// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Covers the FSM encoding and the frame layout constants.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CSUM,
    RUN,
    ERR
  } state_t;

  localparam int          HDR_BYTES      = 2;
  localparam int          BYTES_PER_WORD = 4;
  localparam logic [7:0]  CSUM_INIT      = 8'h00;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and core-control outputs of the loader.
// The slave side is the loader; the master side is the upstream source / system.
interface imem_loader_if #(parameter int ADDR_W = 10);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              done;
   logic              error;

   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error
   );

   modport master (
      output rx_valid, rx_data,
      input  rx_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error
   );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs four accepted bytes into a little-endian 32-bit word.
// word/word_valid are combinational on the 4th byte so the caller can register the write directly.
module byte_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic        word_valid,
   output logic [31:0] word
);

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  idx;
   // Only the three earlier bytes need storing; the 4th arrives on byte_in.
   logic [23:0] hist;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx  <= '0;
         hist <= '0;
      end else if (clear) begin
         idx  <= '0;
      end else if (byte_en) begin
         idx  <= idx + 2'd1;
         hist <= {byte_in, hist[23:8]};
      end
   end

   assign word_valid = byte_en && !clear && (idx == LAST_IDX);
   assign word       = {byte_in, hist};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes words into instruction memory,
// verifies the XOR checksum and then releases the core from reset.
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   imem_loader_if.slave bus
);
   import loader_pkg::*;

   localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

   state_t            state;
   logic [15:0]       cnt;
   logic [ADDR_W:0]   wcnt;
   logic [7:0]        csum;
   logic              rdy;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              core_run;
   logic              done_r;
   logic              err_r;

   logic              accept;
   logic [15:0]       hdr_n;
   logic [ADDR_W:0]   wnext;
   logic              word_valid;
   logic [31:0]       word;

   assign accept = bus.rx_valid && rdy;
   assign hdr_n  = {bus.rx_data, cnt[7:0]};
   assign wnext  = wcnt + 1'b1;

   byte_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (state != DATA),
      .byte_en    (accept && (state == DATA)),
      .byte_in    (bus.rx_data),
      .word_valid (word_valid),
      .word       (word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= HDR0;
         cnt      <= '0;
         wcnt     <= '0;
         csum     <= CSUM_INIT;
         rdy      <= 1'b0;
         we       <= 1'b0;
         addr     <= '0;
         wdata    <= '0;
         core_run <= 1'b0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         we <= 1'b0;
         case (state)
            HDR0: begin
               // rdy comes up here on the first clock after reset release.
               rdy <= 1'b1;
               if (accept) begin
                  cnt[7:0] <= bus.rx_data;
                  wcnt     <= '0;
                  csum     <= CSUM_INIT;
                  state    <= HDR1;
               end
            end
            HDR1: if (accept) begin
               cnt <= hdr_n;
               if (hdr_n == 16'd0) begin
                  state <= CSUM;
               end else if ({1'b0, hdr_n} > DEPTH) begin
                  state <= ERR;
                  err_r <= 1'b1;
                  rdy   <= 1'b0;
               end else begin
                  state <= DATA;
               end
            end
            DATA: if (accept) begin
               csum <= csum ^ bus.rx_data;
               if (word_valid) begin
                  we    <= 1'b1;
                  addr  <= wcnt[ADDR_W-1:0];
                  wdata <= word;
                  wcnt  <= wnext;
                  if (16'(wnext) == cnt) state <= CSUM;
               end
            end
            CSUM: if (accept) begin
               rdy <= 1'b0;
               if (bus.rx_data == csum) begin
                  state    <= RUN;
                  core_run <= 1'b1;
                  done_r   <= 1'b1;
               end else begin
                  state <= ERR;
                  err_r <= 1'b1;
               end
            end
            RUN:     ;
            ERR:     ;
            default: state <= ERR;
         endcase
      end
   end

   assign bus.rx_ready   = rdy;
   assign bus.imem_we    = we;
   assign bus.imem_addr  = addr;
   assign bus.imem_wdata = wdata;
   assign bus.core_rst   = core_run;
   assign bus.done       = done_r;
   assign bus.error      = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: frames are built from word lists,
// expected writes are queued, and a monitor checks every imem_we pulse.
module tb_imem_loader;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int  checks = 0;
   int  errors = 0;
   wr_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every write strobe seen must match the head of the expected queue.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write actual=%h:%h required=none",
                        bus.imem_addr, bus.imem_wdata);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_addr", 32'(bus.imem_addr), e.addr);
               chk("wr_data", bus.imem_wdata, e.data);
            end
         end
      end
   end

   task automatic check_status(input string tag, input bit dn, input bit er, input bit rdy);
      chk({tag, "_done"},     32'(bus.done),     32'(dn));
      chk({tag, "_core_rst"}, 32'(bus.core_rst), 32'(dn));
      chk({tag, "_error"},    32'(bus.error),    32'(er));
      chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'(rdy));
   endtask

   task automatic do_reset();
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("async_core_rst", 32'(bus.core_rst), 32'd0);
      chk("async_rx_ready", 32'(bus.rx_ready), 32'd0);
      repeat (2) @(negedge clk);
      chk("rst_imem_we",    32'(bus.imem_we),  32'd0);
      chk("rst_imem_addr",  32'(bus.imem_addr), 32'd0);
      chk("rst_imem_wdata", bus.imem_wdata,    32'd0);
      check_status("rst", 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
   endtask

   // Starts and returns on a falling edge; the byte transfers on the rising edge in between.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int tmo;
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      tmo = 0;
      while (bus.rx_ready !== 1'b1 && tmo < 20) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 20) begin
         chk("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
         bus.rx_valid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   // csum_sel < 0 sends the correct checksum, otherwise sends csum_sel[7:0].
   task automatic send_frame(input int n, input logic [31:0] words[$], input int csum_sel,
                             input int gapmax);
      logic [7:0] cs;
      logic [7:0] sent;
      bit         good;
      logic [15:0] nn;
      nn = 16'(n);
      cs = 8'h00;
      if (n <= DEPTH) begin
         for (int i = 0; i < n; i++) begin
            wr_t w;
            w.addr = 32'(i);
            w.data = words[i];
            exp_q.push_back(w);
            cs = cs ^ words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
         end
      end
      send_byte(nn[7:0],  $urandom_range(0, gapmax));
      send_byte(nn[15:8], $urandom_range(0, gapmax));
      if (n > DEPTH) begin
         check_status("hdr_err", 1'b0, 1'b1, 1'b0);
         return;
      end
      for (int i = 0; i < n; i++)
         for (int k = 0; k < 4; k++)
            send_byte(8'(words[i] >> (8 * k)), $urandom_range(0, gapmax));
      chk("done_before_csum", 32'(bus.done), 32'd0);
      sent = (csum_sel < 0) ? cs : 8'(csum_sel);
      good = (sent == cs);
      send_byte(sent, $urandom_range(0, gapmax));
      check_status("frame_end", good, !good, 1'b0);
      chk("writes_drained", 32'(exp_q.size()), 32'd0);
      // Trailing input must be ignored.
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
      repeat (3) @(negedge clk);
      bus.rx_valid = 1'b0;
      check_status("idle_after", good, !good, 1'b0);
   endtask

   initial begin
      logic [31:0] ws[$];
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;

      // Directed two-word frame, back-to-back then with gaps, then with a bad checksum.
      ws = '{32'h0000_0513, 32'h0010_0593};
      do_reset();
      send_frame(2, ws, -1, 0);
      do_reset();
      send_frame(2, ws, -1, 3);
      do_reset();
      send_frame(2, ws, 0, 0);

      // Empty frame and oversize count.
      ws = {};
      do_reset();
      send_frame(0, ws, 0, 1);
      do_reset();
      send_frame(DEPTH + 1, ws, -1, 0);
      repeat (4) @(negedge clk);
      chk("oversize_no_writes", 32'(exp_q.size()), 32'd0);

      // Full-capacity load.
      ws = {};
      for (int i = 0; i < DEPTH; i++) ws.push_back($urandom);
      do_reset();
      send_frame(DEPTH, ws, -1, 0);

      // Reset in the middle of a frame: only the first word lands, then a fresh load.
      do_reset();
      begin
         wr_t w;
         w.addr = 32'd0;
         w.data = 32'hCAFE_F00D;
         exp_q.push_back(w);
      end
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h0D, 0);
      send_byte(8'hF0, 0);
      send_byte(8'hFE, 0);
      send_byte(8'hCA, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      chk("partial_write_seen", 32'(exp_q.size()), 32'd0);
      do_reset();
      ws = '{32'h1234_5678};
      send_frame(1, ws, -1, 2);

      // Random frames with random gaps and occasionally corrupted checksums.
      for (int t = 0; t < 8; t++) begin
         int n;
         n  = $urandom_range(1, 9);
         ws = {};
         for (int i = 0; i < n; i++) ws.push_back($urandom);
         do_reset();
         send_frame(n, ws, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1, 3);
      end

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
